// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch with a registered decode slot.
// Define FETCH_BPRED_EN to enable static taken prediction of B instructions.
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] instruction_o,
    output logic [63:0] inst_pc_o,
    output logic [25:0] imm26_o,
    output logic [2:0]  ctrl_o,
    output logic        pred_taken_o
);
    localparam logic [1:0] S_FETCH = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2;

    function automatic logic [2:0] decode(input logic [31:0] w);
        return w[31:26] == 6'b000101 ? 3'b010 :
               w[31:25] == 7'b1011010 ? 3'b011 :
               (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) ? 3'b001 :
               w[31:23] == 9'b110100101 ? 3'b100 :
               (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100 ||
                w[31:22] == 10'b1001001000 || w[31:22] == 10'b1011001000) ? 3'b000 : 3'b111;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d, inst_pc_q, rsp_next;
    logic        inst_valid_q, inst_valid_d, pred_q, rsp_taken;
    logic [31:0] instr_q;
    logic [2:0]  ctrl_q, rsp_ctrl;
    logic        slot_free, hs, load;

    assign rsp_ctrl  = decode(imem_rsp_data_i);
`ifdef FETCH_BPRED_EN
    assign rsp_taken = rsp_ctrl == 3'b010;
    assign rsp_next  = rsp_taken ? pc_q + {{36{imem_rsp_data_i[25]}}, imem_rsp_data_i[25:0], 2'b00}
                                 : pc_q + 64'd4;
`else
    assign rsp_taken = 1'b0;
    assign rsp_next  = pc_q + 64'd4;
`endif

    // Request only when the slot will be free, so a response never lands on a held word.
    assign slot_free        = !inst_valid_q || inst_ready_i;
    assign imem_req_valid_o = !rst_i && state_q == S_FETCH && slot_free;
    assign hs               = imem_req_valid_o && imem_req_ready_i;
    assign load             = state_q == S_WAIT && imem_rsp_valid_i && !redirect_i;

    always_comb begin
        state_d = state_q == S_FETCH ? (hs ? (redirect_i ? S_DROP : S_WAIT) : S_FETCH) :
                  state_q == S_WAIT  ? (imem_rsp_valid_i ? S_FETCH : redirect_i ? S_DROP : S_WAIT) :
                                       (imem_rsp_valid_i ? S_FETCH : S_DROP);
        pc_d         = redirect_i ? redirect_pc_i : load ? rsp_next : pc_q;
        inst_valid_d = redirect_i ? 1'b0 : load ? 1'b1 : inst_valid_q && !inst_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            instr_q      <= 32'h0;
            inst_pc_q    <= 64'h0;
            ctrl_q       <= 3'b111;
            pred_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            if (load) begin
                instr_q   <= imem_rsp_data_i;
                inst_pc_q <= pc_q;
                ctrl_q    <= rsp_ctrl;
                pred_q    <= rsp_taken;
            end
        end
    end

    assign imem_addr_o   = pc_q;
    assign inst_valid_o  = inst_valid_q;
    assign instruction_o = instr_q;
    assign inst_pc_o     = inst_pc_q;
    assign imm26_o       = instr_q[25:0];
    assign ctrl_o        = ctrl_q;
    assign pred_taken_o  = pred_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch sequencing, decode, stall, redirect and reset.
module tb_inst_fetch_unit;
    logic        clk = 1'b0, rst;
    logic        req_valid, req_ready, rsp_valid, redirect, inst_valid, inst_ready, pred;
    logic [63:0] addr, rpc, inst_pc;
    logic [31:0] rsp_data, instruction;
    logic [25:0] imm26;
    logic [2:0]  ctrl;
    int          n_cmp = 0, n_err = 0, lat = 1, cnt;
    logic        pend;
    logic [31:0] mem [logic [63:0]];

    inst_fetch_unit dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .redirect_i(redirect), .redirect_pc_i(rpc),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .instruction_o(instruction), .inst_pc_o(inst_pc), .imm26_o(imm26),
        .ctrl_o(ctrl), .pred_taken_o(pred)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : a[31:0];
    endfunction

    // Memory model: response lat cycles after the accepting edge, cleared by shared reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else begin
            if (pend) begin
                if (cnt == 0) pend <= 1'b0;
                else cnt <= cnt - 1;
            end
            if (req_valid && req_ready) begin
                pend     <= 1'b1;
                cnt      <= lat - 1;
                rsp_data <= word_at(addr);
            end
        end
    end
    assign rsp_valid = pend && cnt == 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        check(tag, inst_valid, 1);
    endtask

    task automatic redirect_to(input logic [63:0] target);
        redirect = 1'b1;
        rpc = target;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    logic [2:0] exp_ctrl [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b111};

    initial begin
        mem[64'h10] = 32'h91000421;
        mem[64'h14] = 32'hF8408020;
        mem[64'h18] = 32'hB4000060;
        mem[64'h1C] = 32'hD2800540;
        mem[64'h20] = 32'h8B020020;
        mem[64'h40] = 32'h17FFFFFE;
        rst = 1'b1; req_ready = 1'b1; inst_ready = 1'b1; redirect = 1'b0; rpc = '0;
        @(negedge clk);
        check("rst_reqv", req_valid, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_ctrl", ctrl, 3'b111);
        check("rst_pred", pred, 0);
        rst = 1'b0;
        #1;
        check("first_reqv", req_valid, 1);
        check("first_addr", addr, 64'h0);
        for (int i = 0; i < 4; i++) begin
            wait_valid($sformatf("seq_v%0d", i));
            check($sformatf("seq_pc%0d", i), inst_pc, 64'(4 * i));
            check($sformatf("seq_addr%0d", i), addr, 64'(4 * i + 4));
            check($sformatf("seq_reqv%0d", i), req_valid, 1);
            @(negedge clk);
            check($sformatf("seq_gap%0d", i), inst_valid, 0);
        end
        for (int i = 0; i < 5; i++) begin
            wait_valid($sformatf("dec_v%0d", i));
            check($sformatf("dec_pc%0d", i), inst_pc, 64'(16 + 4 * i));
            check($sformatf("dec_ctrl%0d", i), ctrl, exp_ctrl[i]);
            if (i == 0) check("dec_imm", imm26, 26'h1000421);
        end
        @(negedge clk);
        inst_ready = 1'b0;
        wait_valid("stall_v");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_v%0d", i), inst_valid, 1);
            check($sformatf("stall_pc%0d", i), inst_pc, 64'h24);
            check($sformatf("stall_w%0d", i), instruction, 32'h24);
            check($sformatf("stall_req%0d", i), req_valid, 0);
        end
        lat = 3;
        inst_ready = 1'b1;
        #1;
        check("release_reqv", req_valid, 1);
        check("release_addr", addr, 64'h28);
        @(negedge clk);
        check("release_clear", inst_valid, 0);
        redirect_to(64'h100);
        check("drop_v1", inst_valid, 0);
        check("drop_req1", req_valid, 0);
        @(negedge clk);
        check("drop_v2", inst_valid, 0);
        check("drop_req2", req_valid, 0);
        lat = 1;
        @(negedge clk);
        check("drop_v3", inst_valid, 0);
        check("drop_reqv", req_valid, 1);
        check("drop_addr", addr, 64'h100);
        wait_valid("r100_v");
        check("r100_pc", inst_pc, 64'h100);
        @(negedge clk);
        redirect_to(64'h200);
        check("rsp_redir_v", inst_valid, 0);
        check("rsp_redir_reqv", req_valid, 1);
        check("rsp_redir_addr", addr, 64'h200);
        wait_valid("r200_v");
        check("r200_pc", inst_pc, 64'h200);
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid("wrap_v");
        check("wrap_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_addr", addr, 64'h0);
        wait_valid("wrap0_v");
        check("wrap0_pc", inst_pc, 64'h0);
        redirect_to(64'h40);
        wait_valid("b_v");
        check("b_pc", inst_pc, 64'h40);
        check("b_word", instruction, 32'h17FFFFFE);
        check("b_ctrl", ctrl, 3'b010);
        check("b_imm", imm26, 26'h3FFFFFE);
`ifdef FETCH_BPRED_EN
        check("b_pred", pred, 1);
        check("b_addr", addr, 64'h38);
`else
        check("b_pred", pred, 0);
        check("b_addr", addr, 64'h44);
`endif
        lat = 3;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", inst_valid, 0);
        check("arst_ctrl", ctrl, 3'b111);
        check("arst_instr", instruction, 0);
        check("arst_pc", inst_pc, 0);
        check("arst_reqv", req_valid, 0);
        check("arst_addr", addr, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        #1;
        check("post_reqv", req_valid, 1);
        check("post_addr", addr, 64'h0);
        wait_valid("post_v");
        check("post_pc", inst_pc, 64'h0);
        check("post_pred", pred, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
